// File: rtl/ext_irq_ctrl.sv
// Machine-external interrupt controller: per-source edge/level pending latch,
// enable mask, fixed lowest-index priority and a REQ/SERVICE claim handshake.

module ext_irq_src_cell (
   input  logic clk_i,
   input  logic reset_i,
   input  logic src,
   input  logic edge_mode,
   input  logic clr,
   output logic pend
);
   logic prev_q;
   logic rise;

   assign rise = src & ~prev_q;

   // Edge mode: a rise in the claim cycle wins over the claim clear.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         prev_q <= 1'b0;
         pend   <= 1'b0;
      end else begin
         prev_q <= src;
         if (edge_mode) pend <= rise | (pend & ~clr);
         else           pend <= src;
      end
   end
endmodule

module ext_irq_ctrl #(
   parameter int NUM_SRC = 8,
   parameter int ID_W    = 3
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic [NUM_SRC-1:0] irq_src_i,
   input  logic [NUM_SRC-1:0] irq_en_i,
   input  logic [NUM_SRC-1:0] irq_edge_i,
   input  logic               irq_ack_i,
   input  logic               irq_done_i,
   output logic               meip_o,
   output logic               claim_valid_o,
   output logic [ID_W-1:0]    claim_id_o,
   output logic [NUM_SRC-1:0] pending_o
);
   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t             state_q, state_d;
   logic [NUM_SRC-1:0] pend_q;
   logic [NUM_SRC-1:0] elig;
   logic [NUM_SRC-1:0] win_oh;
   logic [NUM_SRC-1:0] clr;
   logic [ID_W-1:0]    win_id;
   logic [ID_W-1:0]    claim_id_q;
   logic               take;

   genvar g;
   generate
      for (g = 0; g < NUM_SRC; g++) begin : g_src
         ext_irq_src_cell u_cell (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .src       (irq_src_i[g]),
            .edge_mode (irq_edge_i[g]),
            .clr       (clr[g]),
            .pend      (pend_q[g])
         );
      end
   endgenerate

   assign elig = pend_q & irq_en_i;

   // Scan downward so the lowest set index is the last (winning) assignment.
   always_comb begin
      win_id = '0;
      win_oh = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (elig[i]) begin
            win_id    = ID_W'(i);
            win_oh    = '0;
            win_oh[i] = 1'b1;
         end
      end
   end

   assign take = (state_q == REQ) & irq_ack_i & (|elig);
   assign clr  = take ? win_oh : '0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|elig) state_d = REQ;
         REQ:     if (take) state_d = SERVICE;
                  else if (irq_ack_i || !(|elig)) state_d = IDLE;
         SERVICE: if (irq_done_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         claim_id_q <= '0;
      end else begin
         state_q <= state_d;
         if (take) claim_id_q <= win_id;
      end
   end

   assign meip_o        = (state_q == REQ);
   assign claim_valid_o = (state_q == SERVICE);
   assign claim_id_o    = claim_id_q;
   assign pending_o     = pend_q;
endmodule

// File: doc/ext_irq_ctrl.md
# ext_irq_ctrl

Machine-external interrupt controller placed between the SoC interrupt sources and the core's `meip_i` input in `barebones_wb_top`. It replaces the ad-hoc "drop `meip_i` on `irq_ack_o`" behaviour with four functions:
- latches per-source requests, edge- or level-triggered;
- masks and prioritises them;
- raises `meip_o` and holds it until the core acknowledges;
- reports the claimed source ID until software signals end of service.

## Interface
Parameters:
- `NUM_SRC`, 8: number of external interrupt sources (1..32).
- `ID_W`, 3: width of claim ID; must equal clog2(`NUM_SRC`), minimum 1.

Ports:
- `clk_i`, input, 1: core clock; all state changes on its rising edge.
- `reset_i`, input, 1: synchronous, active-high reset.
- `irq_src_i`, input, `NUM_SRC`: raw requests, already synchronous to `clk_i`.
- `irq_en_i`, input, `NUM_SRC`: per-source enable mask; 1 = eligible.
- `irq_edge_i`, input, `NUM_SRC`: per-source trigger mode; 1 = rising edge, 0 = level-high.
- `irq_ack_i`, input, 1: one-cycle pulse from core `irq_ack_o`.
- `irq_done_i`, input, 1: one-cycle end-of-service pulse (from the MRET/CSR-write decode).
- `meip_o`, output, 1: to core `meip_i`.
- `claim_valid_o`, output, 1: high while a claimed interrupt is in service.
- `claim_id_o`, output, `ID_W`: index of the claimed source.
- `pending_o`, output, `NUM_SRC`: pending register, unmasked.

## Operation
- **Registers:** `prev_q`, `pend_q`, `state_q`, `claim_id_o`.
- **Reset:** `reset_i` = 1 clears every register at the next edge. `meip_o`, `claim_valid_o`, `claim_id_o` and `pending_o` are all 0; the FSM goes to IDLE. This also applies mid-service, so an acknowledged claim is abandoned silently.
- **Edge detect:** `rise[i]` = `irq_src_i[i]` & ~`prev_q[i]`. `prev_q` resets to 0, so a source held high across reset release counts as one rising edge.
- **Pending update, edge mode:**
  - `pend_q[i]` is set on `rise[i]` and cleared when source i is claimed.
  - If the set and the clear occur in the same cycle, the set wins.
- **Pending update, level mode:** `pend_q[i]` <= `irq_src_i[i]` every cycle; claiming does not clear it.
- **Eligibility:** `elig` = `pend_q` & `irq_en_i`.
- **Winner:** the lowest index set in `elig` (index 0 has the highest priority). The winner is evaluated in the ack cycle, not when the request is raised.
- **FSM IDLE:** `meip_o` = 0.
  - `elig` != 0 -> REQ.
  - `irq_ack_i` and `irq_done_i` are ignored.
- **FSM REQ:** `meip_o` = 1.
  - On `irq_ack_i` with `elig` != 0: latch the winner into `claim_id_o`, clear its edge-pending bit, set `claim_valid_o`, go to SERVICE.
  - On `irq_ack_i` with `elig` == 0 (spurious): go to IDLE; `claim_valid_o` stays 0.
  - With no ack and `elig` == 0 (request withdrawn by masking or level drop): go to IDLE.
  - `irq_done_i` is ignored.
- **FSM SERVICE:** `meip_o` = 0; no nesting.
  - `irq_done_i` -> IDLE, clearing `claim_valid_o` (`claim_id_o` holds its value).
  - `irq_ack_i` is ignored.
  - Sources keep pending during SERVICE.
- **Outputs:** `meip_o` is decoded from `state_q` (REQ), so it is registered-state glitch-free. `pending_o` = `pend_q`.

## Timing
- **Request latency:** source rises before edge k -> `pend_q` set after edge k -> REQ and `meip_o` = 1 after edge k+1. Two cycles, identical for both trigger modes.
- **Ack:** `irq_ack_i` sampled at edge m -> after edge m: `meip_o` = 0, `claim_valid_o` = 1, `claim_id_o` valid, the edge-pending bit of the winner cleared.
- **Done:** `irq_done_i` sampled at edge d -> IDLE after d. If `elig` != 0, REQ follows after d+1, so there is a minimum one-cycle `meip_o` low gap between services.
- **Ack in the transition cycle:** an ack coinciding with the IDLE->REQ transition is ignored, since the state was not yet REQ when sampled.
- **Withdrawal:** `meip_o` falls the cycle after `elig` becomes 0.

## Test plan
- **Reset:** hold `reset_i` = 1 for 3 cycles with `irq_src_i` = 8'hFF -> all outputs 0 throughout. After release, with `irq_edge_i` = 8'hFF and `irq_en_i` = 8'hFF: `pending_o` = 8'hFF one cycle later and `meip_o` = 1 two cycles later.
- **Edge single:** pulse `irq_src_i[5]` for one cycle with en = 8'hFF, edge = 8'hFF -> `meip_o` = 1 two cycles later. Ack -> `claim_id_o` = 5, `claim_valid_o` = 1, `pending_o` = 0, `meip_o` = 0. Done -> `claim_valid_o` = 0, `meip_o` stays 0.
- **Priority:** pend sources 6 and 2, then ack -> `claim_id_o` = 2 and `pending_o` = 8'h40. Done -> `meip_o` = 1 again after 2 cycles; next ack -> `claim_id_o` = 6.
- **Level and mask:** source 3 level, held high, ack then done -> `meip_o` reasserts. Drive `irq_en_i[3]` = 0 while in REQ -> `meip_o` = 0 on the next cycle, FSM in IDLE, `pending_o[3]` = 1.
- **Collisions:** rising edge on source 1 in the same cycle it is claimed -> `pending_o[1]` = 1 after ack. Spurious ack (withdraw, then ack) -> `claim_valid_o` stays 0. Assert `reset_i` during SERVICE -> `claim_valid_o` = 0 and `claim_id_o` = 0 the next cycle.
